// File: rtl/exu_div_sched_if.sv
// Decode/divider-side bus of the shared divide scheduler.
// The slave modport is the scheduler; the master side is decode, TLU and the divider.
interface exu_div_sched_if #(
    parameter int XLEN  = 32,
    parameter int TAG_W = 5
);
    logic             flush_lower;
    logic             i0_valid;
    logic             i0_unsign;
    logic             i0_rem;
    logic [XLEN-1:0]  i0_rs1;
    logic [XLEN-1:0]  i0_rs2;
    logic [TAG_W-1:0] i0_tag;
    logic             i1_valid;
    logic             i1_unsign;
    logic             i1_rem;
    logic [XLEN-1:0]  i1_rs1;
    logic [XLEN-1:0]  i1_rs2;
    logic [TAG_W-1:0] i1_tag;
    logic             i0_ack;
    logic             i1_ack;
    logic             div_start;
    logic             div_unsign;
    logic             div_rem;
    logic [XLEN-1:0]  div_dividend;
    logic [XLEN-1:0]  div_divisor;
    logic             div_cancel;
    logic             div_done_in;
    logic [XLEN-1:0]  div_result_in;
    logic             res_valid;
    logic [XLEN-1:0]  res_data;
    logic [TAG_W-1:0] res_tag;
    logic             stall;
    logic             err_drop;
    logic             err_timeout;

    modport slave (
        input  flush_lower,
        input  i0_valid, i0_unsign, i0_rem, i0_rs1, i0_rs2, i0_tag,
        input  i1_valid, i1_unsign, i1_rem, i1_rs1, i1_rs2, i1_tag,
        input  div_done_in, div_result_in,
        output i0_ack, i1_ack,
        output div_start, div_unsign, div_rem, div_dividend, div_divisor, div_cancel,
        output res_valid, res_data, res_tag,
        output stall, err_drop, err_timeout
    );

    modport master (
        output flush_lower,
        output i0_valid, i0_unsign, i0_rem, i0_rs1, i0_rs2, i0_tag,
        output i1_valid, i1_unsign, i1_rem, i1_rs1, i1_rs2, i1_tag,
        output div_done_in, div_result_in,
        input  i0_ack, i1_ack,
        input  div_start, div_unsign, div_rem, div_dividend, div_divisor, div_cancel,
        input  res_valid, res_data, res_tag,
        input  stall, err_drop, err_timeout
    );
endinterface

// File: rtl/exu_div_sched.sv
// Shares one iterative divider between EXU slots I0 and I1: issue, one-entry
// pending buffer for the younger slot, result return, flush cancel and watchdog.
module exu_div_sched #(
    parameter int XLEN    = 32,
    parameter int TAG_W   = 5,
    parameter int TIMEOUT = 40
) (
    input logic            clk,
    input logic            rst_l,
    exu_div_sched_if.slave bus
);
    localparam int CNT_W = $clog2(TIMEOUT + 1);
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(TIMEOUT - 1);
    localparam logic [CNT_W-1:0] CNT_MAX  = CNT_W'(TIMEOUT);

    typedef enum logic {IDLE, BUSY} state_e;

    state_e           state_q;
    logic [CNT_W-1:0] cnt_q;
    logic [CNT_W-1:0] cnt_d;

    logic             pend_v_q;
    logic             pend_unsign_q;
    logic             pend_rem_q;
    logic [XLEN-1:0]  pend_rs1_q;
    logic [XLEN-1:0]  pend_rs2_q;
    logic [TAG_W-1:0] pend_tag_q;
    logic [TAG_W-1:0] cur_tag_q;

    logic             start_q;
    logic             unsign_q;
    logic             rem_q;
    logic [XLEN-1:0]  dividend_q;
    logic [XLEN-1:0]  divisor_q;
    logic             cancel_q;
    logic             res_valid_q;
    logic [XLEN-1:0]  res_data_q;
    logic [TAG_W-1:0] res_tag_q;
    logic             err_drop_q;
    logic             err_to_q;

    logic             stall;
    logic             accept;
    logic             wd_fire;

    logic             iss_unsign;
    logic             iss_rem;
    logic [XLEN-1:0]  iss_rs1;
    logic [XLEN-1:0]  iss_rs2;
    logic [TAG_W-1:0] iss_tag;

    // Stall depends only on registered state, never on the incoming requests.
    assign stall   = (state_q == BUSY) | pend_v_q | start_q;
    assign accept  = (state_q == IDLE) & ~stall & ~bus.flush_lower;
    assign wd_fire = (state_q == BUSY) & ~bus.div_done_in & (cnt_q >= CNT_LAST);
    assign cnt_d   = (cnt_q == CNT_MAX) ? cnt_q : cnt_q + 1'b1;

    assign bus.i0_ack       = accept & bus.i0_valid;
    assign bus.i1_ack       = accept & bus.i1_valid;
    assign bus.stall        = stall;
    assign bus.div_start    = start_q;
    assign bus.div_unsign   = unsign_q;
    assign bus.div_rem      = rem_q;
    assign bus.div_dividend = dividend_q;
    assign bus.div_divisor  = divisor_q;
    assign bus.div_cancel   = cancel_q;
    assign bus.res_valid    = res_valid_q;
    assign bus.res_data     = res_data_q;
    assign bus.res_tag      = res_tag_q;
    assign bus.err_drop     = err_drop_q;
    assign bus.err_timeout  = err_to_q;

    // Op to issue: a fresh request when idle (I0 first), otherwise the pending entry.
    always_comb begin
        iss_unsign = pend_unsign_q;
        iss_rem    = pend_rem_q;
        iss_rs1    = pend_rs1_q;
        iss_rs2    = pend_rs2_q;
        iss_tag    = pend_tag_q;
        if (state_q == IDLE) begin
            if (bus.i0_valid) begin
                iss_unsign = bus.i0_unsign;
                iss_rem    = bus.i0_rem;
                iss_rs1    = bus.i0_rs1;
                iss_rs2    = bus.i0_rs2;
                iss_tag    = bus.i0_tag;
            end else begin
                iss_unsign = bus.i1_unsign;
                iss_rem    = bus.i1_rem;
                iss_rs1    = bus.i1_rs1;
                iss_rs2    = bus.i1_rs2;
                iss_tag    = bus.i1_tag;
            end
        end
    end

    always_ff @(posedge clk or negedge rst_l) begin
        if (!rst_l) begin
            state_q       <= IDLE;
            cnt_q         <= '0;
            pend_v_q      <= 1'b0;
            pend_unsign_q <= 1'b0;
            pend_rem_q    <= 1'b0;
            pend_rs1_q    <= '0;
            pend_rs2_q    <= '0;
            pend_tag_q    <= '0;
            cur_tag_q     <= '0;
            start_q       <= 1'b0;
            unsign_q      <= 1'b0;
            rem_q         <= 1'b0;
            dividend_q    <= '0;
            divisor_q     <= '0;
            cancel_q      <= 1'b0;
            res_valid_q   <= 1'b0;
            res_data_q    <= '0;
            res_tag_q     <= '0;
            err_drop_q    <= 1'b0;
            err_to_q      <= 1'b0;
        end else begin
            start_q     <= 1'b0;
            cancel_q    <= 1'b0;
            res_valid_q <= 1'b0;
            err_to_q    <= 1'b0;
            err_drop_q  <= stall & (bus.i0_valid | bus.i1_valid);

            if (bus.flush_lower) begin
                // A killed op never reports, even if the divider finishes this cycle.
                cancel_q <= (state_q == BUSY) | start_q;
                pend_v_q <= 1'b0;
                state_q  <= IDLE;
                cnt_q    <= '0;
            end else if (state_q == IDLE) begin
                if (accept && (bus.i0_valid || bus.i1_valid)) begin
                    state_q    <= BUSY;
                    start_q    <= 1'b1;
                    cnt_q      <= '0;
                    unsign_q   <= iss_unsign;
                    rem_q      <= iss_rem;
                    dividend_q <= iss_rs1;
                    divisor_q  <= iss_rs2;
                    cur_tag_q  <= iss_tag;
                    if (bus.i0_valid && bus.i1_valid) begin
                        pend_v_q      <= 1'b1;
                        pend_unsign_q <= bus.i1_unsign;
                        pend_rem_q    <= bus.i1_rem;
                        pend_rs1_q    <= bus.i1_rs1;
                        pend_rs2_q    <= bus.i1_rs2;
                        pend_tag_q    <= bus.i1_tag;
                    end
                end
            end else begin
                cnt_q <= cnt_d;
                if (bus.div_done_in || wd_fire) begin
                    if (bus.div_done_in) begin
                        res_valid_q <= 1'b1;
                        res_data_q  <= bus.div_result_in;
                        res_tag_q   <= cur_tag_q;
                    end else begin
                        cancel_q <= 1'b1;
                        err_to_q <= 1'b1;
                    end
                    cnt_q <= '0;
                    if (pend_v_q) begin
                        pend_v_q   <= 1'b0;
                        start_q    <= 1'b1;
                        unsign_q   <= iss_unsign;
                        rem_q      <= iss_rem;
                        dividend_q <= iss_rs1;
                        divisor_q  <= iss_rs2;
                        cur_tag_q  <= iss_tag;
                    end else begin
                        state_q <= IDLE;
                    end
                end
            end
        end
    end
endmodule

// File: tb/tb_exu_div_sched.sv
// Scoreboard bench for exu_div_sched with a behavioural divider stub.
module tb_exu_div_sched;
    localparam int XLEN    = 32;
    localparam int TAG_W   = 5;
    localparam int TIMEOUT = 40;

    typedef struct {
        logic             unsign;
        logic             rem;
        logic [XLEN-1:0]  a;
        logic [XLEN-1:0]  b;
        logic [TAG_W-1:0] tag;
    } op_t;

    typedef struct {
        logic [XLEN-1:0]  data;
        logic [TAG_W-1:0] tag;
    } res_t;

    logic clk = 1'b0;
    logic rst_l = 1'b0;
    always #5 clk = ~clk;

    exu_div_sched_if #(.XLEN(XLEN), .TAG_W(TAG_W)) bus();
    exu_div_sched #(.XLEN(XLEN), .TAG_W(TAG_W), .TIMEOUT(TIMEOUT)) dut (
        .clk   (clk),
        .rst_l (rst_l),
        .bus   (bus)
    );

    int n_chk = 0;
    int n_pass = 0;
    int cyc = 0;
    int done_cyc = 0;
    int n_cancel_obs = 0, n_to_obs = 0, n_drop_obs = 0;
    int n_cancel_exp = 0, n_to_exp = 0, n_drop_exp = 0;

    op_t  start_q[$];
    res_t res_q[$];
    int   delay_q[$];
    int   start_log[$];
    int   res_log[$];

    always @(posedge clk) cyc <= cyc + 1;

    task automatic chk(input string name, input logic [63:0] got, input logic [63:0] exp);
        n_chk++;
        if (got === exp) n_pass++;
        else $display("FAIL %s: got 0x%0h expected 0x%0h at t=%0t", name, got, exp, $time);
    endtask

    // Architectural divide/remainder result, RISC-V M-extension rules.
    function automatic logic [XLEN-1:0] ref_div(input logic unsign, input logic rem,
                                                input logic [XLEN-1:0] a, input logic [XLEN-1:0] b);
        longint sa, sb, q;
        if (b == 0) return rem ? a : '1;
        if (unsign) return rem ? (a % b) : (a / b);
        if (a == 32'h8000_0000 && b == 32'hFFFF_FFFF) return rem ? '0 : a;
        sa = longint'($signed(a));
        sb = longint'($signed(b));
        q  = rem ? (sa % sb) : (sa / sb);
        return q[XLEN-1:0];
    endfunction

    // Divider stub: finishes an op a scheduled number of cycles after its start.
    initial begin : stub
        bit sbusy;
        int scnt;
        logic [XLEN-1:0] srslt;
        sbusy = 0;
        scnt = 0;
        srslt = '0;
        bus.div_done_in = 1'b0;
        bus.div_result_in = '0;
        forever begin
            @(negedge clk);
            bus.div_done_in = 1'b0;
            if (!rst_l) begin
                sbusy = 0;
                continue;
            end
            if (bus.div_cancel) sbusy = 0;
            if (bus.div_start) begin
                scnt  = (delay_q.size() != 0) ? delay_q.pop_front() : -1;
                sbusy = 1;
                srslt = ref_div(bus.div_unsign, bus.div_rem, bus.div_dividend, bus.div_divisor);
            end else if (sbusy && scnt > 0) begin
                scnt--;
                if (scnt == 0) begin
                    bus.div_done_in   = 1'b1;
                    bus.div_result_in = srslt;
                    done_cyc = cyc;
                    sbusy = 0;
                end
            end
        end
    end

    always @(negedge clk) begin : monitor
        op_t  e;
        res_t r;
        if (rst_l) begin
            if (bus.div_start) begin
                start_log.push_back(cyc);
                chk("start_expected", start_q.size() != 0, 1);
                if (start_q.size() != 0) begin
                    e = start_q.pop_front();
                    chk("div_unsign", bus.div_unsign, e.unsign);
                    chk("div_rem", bus.div_rem, e.rem);
                    chk("div_dividend", bus.div_dividend, e.a);
                    chk("div_divisor", bus.div_divisor, e.b);
                end
            end
            if (bus.res_valid) begin
                res_log.push_back(cyc);
                chk("res_expected", res_q.size() != 0, 1);
                chk("res_latency", cyc - done_cyc, 1);
                if (res_q.size() != 0) begin
                    r = res_q.pop_front();
                    chk("res_data", bus.res_data, r.data);
                    chk("res_tag", bus.res_tag, r.tag);
                end
            end
            if (bus.div_cancel) n_cancel_obs++;
            if (bus.err_timeout) n_to_obs++;
            if (bus.err_drop) n_drop_obs++;
        end
    end

    task automatic drive(input bit v0, input op_t o0, input bit v1, input op_t o1);
        bus.i0_valid = v0; bus.i0_unsign = o0.unsign; bus.i0_rem = o0.rem;
        bus.i0_rs1 = o0.a; bus.i0_rs2 = o0.b; bus.i0_tag = o0.tag;
        bus.i1_valid = v1; bus.i1_unsign = o1.unsign; bus.i1_rem = o1.rem;
        bus.i1_rs1 = o1.a; bus.i1_rs2 = o1.b; bus.i1_tag = o1.tag;
    endtask

    task automatic clear_in();
        op_t z;
        z = '{default: '0};
        drive(0, z, 0, z);
    endtask

    task automatic expect_op(input op_t o, input int d);
        start_q.push_back(o);
        delay_q.push_back(d);
        if (d > 0) res_q.push_back('{ref_div(o.unsign, o.rem, o.a, o.b), o.tag});
    endtask

    // Request from an idle scheduler: acks expected on every valid slot.
    task automatic issue(input bit v0, input op_t o0, input int d0,
                         input bit v1, input op_t o1, input int d1);
        @(negedge clk);
        drive(v0, o0, v1, o1);
        #1;
        chk("i0_ack", bus.i0_ack, v0);
        chk("i1_ack", bus.i1_ack, v1);
        if (v0) expect_op(o0, d0);
        if (v1) expect_op(o1, d1);
        @(posedge clk);
        #1;
        clear_in();
    endtask

    // Request while the scheduler is stalled: refused and flagged.
    task automatic drop_req(input bit v0, input op_t o0, input bit v1, input op_t o1);
        @(negedge clk);
        drive(v0, o0, v1, o1);
        #1;
        chk("drop_stall", bus.stall, 1);
        chk("drop_i0_ack", bus.i0_ack, 0);
        chk("drop_i1_ack", bus.i1_ack, 0);
        n_drop_exp++;
        @(posedge clk);
        #1;
        clear_in();
    endtask

    task automatic wait_drain(input string name);
        bit ok;
        ok = 0;
        for (int i = 0; i < 400; i++) begin
            @(negedge clk);
            #2;
            if (res_q.size() == 0 && start_q.size() == 0) begin
                ok = 1;
                break;
            end
        end
        chk({"drain_", name}, ok, 1);
        chk({"stall_after_", name}, bus.stall, 0);
    endtask

    function automatic op_t mk(input logic u, input logic r, input logic [XLEN-1:0] a,
                               input logic [XLEN-1:0] b, input logic [TAG_W-1:0] t);
        op_t o;
        o.unsign = u; o.rem = r; o.a = a; o.b = b; o.tag = t;
        return o;
    endfunction

    function automatic op_t rnd_op();
        op_t o;
        int sel;
        o.unsign = 1'($urandom_range(0, 1));
        o.rem    = 1'($urandom_range(0, 1));
        o.a      = $urandom;
        o.b      = $urandom;
        o.tag    = TAG_W'($urandom);
        sel = int'($urandom_range(0, 7));
        if (sel == 0) o.b = '0;
        if (sel == 1) begin o.a = 32'h8000_0000; o.b = 32'hFFFF_FFFF; end
        if (sel == 2) o.b = XLEN'($urandom_range(1, 15));
        return o;
    endfunction

    initial begin : watchdog
        #1_000_000;
        $display("FAIL global_timeout: simulation did not finish");
        $fatal(1);
    end

    initial begin : stim
        op_t z, o0, o1;
        int d0, d1, mode;
        z = '{default: '0};
        bus.flush_lower = 1'b0;
        clear_in();

        // reset state
        repeat (3) @(negedge clk);
        chk("rst_stall", bus.stall, 0);
        chk("rst_pulses", {bus.div_start, bus.div_cancel, bus.res_valid, bus.err_drop, bus.err_timeout}, 0);
        chk("rst_ops", {bus.div_unsign, bus.div_rem, bus.div_dividend, bus.div_divisor}, 0);
        chk("rst_res", {bus.res_data, bus.res_tag}, 0);
        chk("rst_acks", {bus.i0_ack, bus.i1_ack}, 0);
        rst_l = 1'b1;
        for (int i = 0; i < 4; i++) begin
            @(negedge clk);
            chk("idle_quiet", {bus.div_start, bus.div_cancel, bus.res_valid, bus.err_drop,
                               bus.err_timeout, bus.stall}, 0);
        end

        // single unsigned divide, long divider latency
        issue(1, mk(1, 0, 32'h100, 32'h2, 5), 34, 0, z, 0);
        @(negedge clk);
        chk("t2_start_next_cycle", bus.div_start, 1);
        chk("t2_stall_busy", bus.stall, 1);
        wait_drain("single");

        // dual issue: second start coincides with first result
        start_log.delete();
        res_log.delete();
        issue(1, mk(0, 0, 32'h64, 32'hA, 3), 5, 1, mk(0, 1, 32'h64, 32'h7, 4), 3);
        wait_drain("dual");
        chk("t3_log_sizes", (start_log.size() >= 2) && (res_log.size() >= 1), 1);
        if (start_log.size() >= 2 && res_log.size() >= 1)
            chk("t3_restart_with_res", start_log[1], res_log[0]);

        // flush while busy with pending full, request in the flush cycle
        issue(1, mk(1, 0, 32'h1234, 32'h5, 7), 60, 1, mk(1, 1, 32'h999, 32'h4, 8), 3);
        repeat (9) @(negedge clk);
        @(negedge clk);
        bus.flush_lower = 1'b1;
        drive(1, mk(0, 0, 32'h50, 32'h5, 9), 0, z);
        #1;
        chk("flush_no_ack", bus.i0_ack, 0);
        start_q.delete();
        delay_q.delete();
        res_q.delete();
        n_cancel_exp++;
        n_drop_exp++;
        @(posedge clk);
        #1;
        bus.flush_lower = 1'b0;
        clear_in();
        @(negedge clk);
        chk("flush_cancel", bus.div_cancel, 1);
        chk("flush_no_res", bus.res_valid, 0);
        chk("flush_idle", bus.stall, 0);
        @(negedge clk);
        chk("flush_cancel_one_cycle", {bus.div_cancel, bus.div_start, bus.res_valid, bus.stall}, 0);

        // flush in the same cycle the divider finishes
        issue(1, mk(1, 0, 32'h77, 32'h7, 10), 6, 0, z, 0);
        repeat (6) @(negedge clk);
        @(negedge clk);
        bus.flush_lower = 1'b1;
        res_q.delete();
        n_cancel_exp++;
        @(posedge clk);
        #1;
        bus.flush_lower = 1'b0;
        @(negedge clk);
        chk("flush_done_no_res", bus.res_valid, 0);
        chk("flush_done_cancel", bus.div_cancel, 1);

        // flush while idle: nothing to cancel
        @(negedge clk);
        bus.flush_lower = 1'b1;
        @(posedge clk);
        #1;
        bus.flush_lower = 1'b0;
        @(negedge clk);
        chk("idle_flush_no_cancel", bus.div_cancel, 0);

        // dropped request, in-flight op still completes
        issue(0, z, 0, 1, mk(0, 0, 32'hFFFF_FF00, 32'h10, 11), 12);
        repeat (2) @(negedge clk);
        drop_req(1, mk(1, 0, 32'h10, 32'h2, 12), 0, z);
        @(negedge clk);
        chk("err_drop_pulse", bus.err_drop, 1);
        wait_drain("drop");

        // watchdog, no pending
        issue(1, mk(1, 0, 32'hDEAD, 32'h3, 13), -1, 0, z, 0);
        n_cancel_exp++;
        n_to_exp++;
        for (int k = 1; k <= TIMEOUT + 1; k++) begin
            @(negedge clk);
            if (k <= TIMEOUT) chk("to_wait", {bus.div_cancel, bus.err_timeout, bus.stall}, 3'b001);
            else chk("to_fire", {bus.div_cancel, bus.err_timeout, bus.stall, bus.res_valid}, 4'b1100);
        end
        issue(1, mk(1, 1, 32'h3E8, 32'h7, 14), 4, 0, z, 0);
        wait_drain("after_timeout");

        // watchdog with pending: pending issues in the cancel cycle
        issue(1, mk(0, 0, 32'h1, 32'h1, 15), -1, 1, mk(0, 0, 32'hFFFF_FF9C, 32'h7, 16), 3);
        n_cancel_exp++;
        n_to_exp++;
        repeat (TIMEOUT) @(negedge clk);
        @(negedge clk);
        chk("to_pend_fire", {bus.div_cancel, bus.err_timeout, bus.div_start, bus.stall}, 4'b1111);
        wait_drain("timeout_pending");

        // asynchronous reset mid-busy
        issue(1, mk(1, 0, 32'h4000, 32'h4, 17), 20, 1, mk(1, 0, 32'h40, 32'h4, 18), 2);
        repeat (5) @(negedge clk);
        #1;
        rst_l = 1'b0;
        #1;
        chk("arst_clear", {bus.stall, bus.div_start, bus.res_valid, bus.div_cancel}, 0);
        chk("arst_ops", {bus.div_dividend, bus.div_divisor}, 0);
        start_q.delete();
        delay_q.delete();
        res_q.delete();
        @(negedge clk);
        rst_l = 1'b1;
        repeat (2) @(negedge clk);
        chk("arst_quiet", {bus.div_start, bus.div_cancel, bus.res_valid, bus.stall}, 0);

        // randomized traffic
        for (int it = 0; it < 40; it++) begin
            mode = int'($urandom_range(0, 2));
            o0 = rnd_op();
            o1 = rnd_op();
            d0 = int'($urandom_range(1, 8));
            d1 = int'($urandom_range(1, 8));
            if (mode == 0) issue(1, o0, d0, 0, z, 0);
            else if (mode == 1) issue(0, z, 0, 1, o1, d1);
            else issue(1, o0, d0, 1, o1, d1);
            if ($urandom_range(0, 2) == 0) drop_req(1, rnd_op(), 1'($urandom_range(0, 1)), rnd_op());
            wait_drain("rand");
        end

        repeat (3) @(negedge clk);
        chk("cancel_count", n_cancel_obs, n_cancel_exp);
        chk("timeout_count", n_to_obs, n_to_exp);
        chk("drop_count", n_drop_obs, n_drop_exp);

        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end
endmodule
